// File: rtl/sram_mem_stage.sv
// MEM pipeline stage driving a 16-bit asynchronous SRAM as two half-word phases (LO, HI).
// Optional macro SRAM_WAIT_EN stretches each phase to WAIT_CYCLES+1 cycles.
module sram_mem_stage #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_enable_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [31:0] alu_res_in,
   input  logic [31:0] val_rm_in,
   input  logic [3:0]  dest_in,
   output logic        wb_enable_out,
   output logic        mem_read_out,
   output logic [31:0] alu_res_out,
   output logic [3:0]  dest_out,
   output logic [31:0] mem_data_out,
   output logic        ready_out,
   output logic        freeze_out,
   output logic [17:0] sram_addr,
   output logic        sram_we_n,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      r_state;
   logic [15:0] r_rd_lo;
   logic [31:0] r_mem_data;

   logic        w_req;
   logic        w_write;
   logic        w_phase_last;
   logic [31:0] w_offset;
   logic [16:0] w_word;
   logic        w_unused_addr_bits;

   assign w_req   = mem_read_in | mem_write_in;
   // A simultaneous read+write request is treated as a write.
   assign w_write = mem_write_in;

   assign w_offset           = alu_res_in - 32'(BASE_ADDR);
   assign w_word             = w_offset[18:2];
   assign w_unused_addr_bits = &{1'b0, w_offset[31:19], w_offset[1:0]};

`ifdef SRAM_WAIT_EN
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

   logic [CW-1:0] r_wait_cnt;

   assign w_phase_last = (r_wait_cnt == '0);

   // Reloaded on entry to LO and to HI; counts down while a phase is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if ((r_state == IDLE && w_req) || (r_state == LO && w_phase_last)) begin
         r_wait_cnt <= WAIT_LOAD;
      end else if (r_wait_cnt != '0) begin
         r_wait_cnt <= r_wait_cnt - 1'b1;
      end
   end
`else
   assign w_phase_last = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_rd_lo    <= '0;
         r_mem_data <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_req) r_state <= LO;
            LO: begin
               if (w_phase_last) begin
                  if (!w_write) r_rd_lo <= sram_dq_in;
                  r_state <= HI;
               end
            end
            HI: begin
               if (w_phase_last) begin
                  if (!w_write) r_mem_data <= {sram_dq_in, r_rd_lo};
                  r_state <= DONE;
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      sram_addr   = '0;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_dq_out = '0;
      case (r_state)
         LO: begin
            sram_addr = {w_word, 1'b0};
            if (w_write) begin
               sram_we_n   = 1'b0;
               sram_dq_oe  = 1'b1;
               sram_dq_out = val_rm_in[15:0];
            end
         end
         HI: begin
            sram_addr = {w_word, 1'b1};
            if (w_write) begin
               sram_we_n   = 1'b0;
               sram_dq_oe  = 1'b1;
               sram_dq_out = val_rm_in[31:16];
            end
         end
         default: ;
      endcase
   end

   // Stall starts in the IDLE cycle that sees the request; DONE releases it.
   assign ready_out  = !((r_state == IDLE && w_req) || r_state == LO || r_state == HI);
   assign freeze_out = ~ready_out;

   assign wb_enable_out = wb_enable_in;
   assign mem_read_out  = mem_read_in;
   assign alu_res_out   = alu_res_in;
   assign dest_out      = dest_in;
   assign mem_data_out  = r_mem_data;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Scoreboard bench for sram_mem_stage with a behavioural 16-bit SRAM model.
module tb_sram_mem_stage;

   localparam int BASE = 1024;
   localparam int WAIT = 2;
`ifdef SRAM_WAIT_EN
   localparam int PH = WAIT + 1;
`else
   localparam int PH = 1;
`endif
   localparam int STALL = 1 + 2 * PH;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_enable_in, mem_read_in, mem_write_in;
   logic [31:0] alu_res_in, val_rm_in;
   logic [3:0]  dest_in;
   logic        wb_enable_out, mem_read_out;
   logic [31:0] alu_res_out, mem_data_out;
   logic [3:0]  dest_out;
   logic        ready_out, freeze_out;
   logic [17:0] sram_addr;
   logic        sram_we_n, sram_dq_oe;
   logic [15:0] sram_dq_out, sram_dq_in;

   logic [15:0] sram [0:255];
   logic [15:0] ref_mem [int];
   logic [31:0] exp_q [$];
   logic [31:0] last_rd;

   int n_cmp = 0;
   int n_bad = 0;

   sram_mem_stage #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst(rst),
      .wb_enable_in(wb_enable_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
      .wb_enable_out(wb_enable_out), .mem_read_out(mem_read_out),
      .alu_res_out(alu_res_out), .dest_out(dest_out),
      .mem_data_out(mem_data_out), .ready_out(ready_out), .freeze_out(freeze_out),
      .sram_addr(sram_addr), .sram_we_n(sram_we_n),
      .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!sram_we_n && sram_dq_oe) sram[sram_addr[7:0]] <= sram_dq_out;

   assign sram_dq_in = sram[sram_addr[7:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] off;
      logic [17:0] lo_a;
      int          low, bad;
      logic        done;
      logic [31:0] e_addr, e_dq;
      logic        e_we;
      off  = addr - 32'(BASE);
      lo_a = {off[18:2], 1'b0};
      @(posedge clk); #1;
      mem_read_in  = rd;
      mem_write_in = wr;
      alu_res_in   = addr;
      val_rm_in    = data;
      dest_in      = 4'($urandom_range(0, 15));
      wb_enable_in = 1'b1;
      if (wr) begin
         ref_mem[int'(lo_a)]     = data[15:0];
         ref_mem[int'(lo_a) + 1] = data[31:16];
         exp_q.push_back({16'h0, data[15:0]});
         exp_q.push_back({16'h0, data[31:16]});
      end else begin
         exp_q.push_back({ref_mem[int'(lo_a) + 1], ref_mem[int'(lo_a)]});
      end
      low = 0; bad = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (ready_out) begin
            done = 1'b1;
         end else begin
            e_addr = (low == 0) ? 32'h0 : (low <= PH) ? 32'(lo_a) : 32'(lo_a) + 1;
            e_we   = !(wr && low > 0);
            e_dq   = (low <= PH) ? {16'h0, data[15:0]} : {16'h0, data[31:16]};
            if (32'(sram_addr) != e_addr || sram_we_n != e_we || sram_dq_oe != !e_we) bad++;
            if (!e_we && 32'(sram_dq_out) != e_dq) bad++;
            if (!freeze_out || dest_out != dest_in || alu_res_out != addr || mem_read_out != rd) bad++;
            low++;
         end
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_stall"}, low, STALL);
      chk({tag, "_seq"}, bad, 0);
      if (!wr) begin
         last_rd = exp_q.pop_front();
         chk({tag, "_data"}, mem_data_out, last_rd);
      end
      @(posedge clk); #1;
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
      if (wr) begin
         chk({tag, "_lo"}, {16'h0, sram[lo_a[7:0]]}, exp_q.pop_front());
         chk({tag, "_hi"}, {16'h0, sram[lo_a[7:0] + 8'd1]}, exp_q.pop_front());
         chk({tag, "_hold"}, mem_data_out, last_rd);
      end
   endtask

   initial begin
      int bad;
      rst = 1'b1; wb_enable_in = 0; mem_read_in = 0; mem_write_in = 0;
      alu_res_in = 0; val_rm_in = 0; dest_in = 0; last_rd = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(ready_out), 1);
      chk("rst_we_n", 32'(sram_we_n), 1);
      chk("rst_oe", 32'(sram_dq_oe), 0);
      chk("rst_addr", 32'(sram_addr), 0);
      chk("rst_data", mem_data_out, 0);

      access("st1024", 1'b0, 1'b1, 32'd1024, 32'h12345678);
      access("ld1024", 1'b1, 1'b0, 32'd1024, 32'h0);

      @(posedge clk); #1;
      alu_res_in = 32'hDEAD; dest_in = 4'h7; wb_enable_in = 1'b1;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (!ready_out || freeze_out || !sram_we_n || sram_dq_oe || sram_addr != 0) bad++;
      end
      chk("nomem_idle", bad, 0);
      chk("nomem_alu", alu_res_out, 32'hDEAD);
      chk("nomem_dest", 32'(dest_out), 7);
      chk("nomem_wb", 32'(wb_enable_out), 1);

      access("rw1028", 1'b1, 1'b1, 32'd1028, 32'hAAAA5555);
      access("ld1028", 1'b1, 1'b0, 32'd1028, 32'h0);
      access("st1032", 1'b0, 1'b1, 32'd1032, 32'hCAFEBEEF);
      access("ld1032", 1'b1, 1'b0, 32'd1032, 32'h0);
      access("stwrap", 1'b0, 1'b1, 32'd1020, 32'h0F0E0D0C);
      access("ldwrap", 1'b1, 1'b0, 32'd1020, 32'h0);

      // Reset while the HI phase of a store is in progress.
      @(posedge clk); #1;
      mem_write_in = 1'b1; alu_res_in = 32'd1040; val_rm_in = 32'h0BADF00D;
      repeat (1 + PH) @(posedge clk);
      #1 rst = 1'b1; mem_write_in = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rmid_ready", 32'(ready_out), 1);
      chk("rmid_we_n", 32'(sram_we_n), 1);
      chk("rmid_oe", 32'(sram_dq_oe), 0);
      chk("rmid_data", mem_data_out, 0);
      chk("rmid_lo_kept", {16'h0, sram[8]}, 32'h0000F00D);
      last_rd = 0;

      access("ld_after", 1'b1, 1'b0, 32'd1024, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_mem_stage.md
SRAM_MEM_STAGE -- requirements
Module: sram_mem_stage

Interface
REQ-001 Parameter BASE_ADDR, default 1024, byte address of data-memory word 0.
REQ-002 Parameter WAIT_CYCLES, default 2, extra cycles per SRAM half-word phase; used only with SRAM_WAIT_EN.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wb_enable_in, mem_read_in, mem_write_in  in  1 each  control bits from the EXE/MEM register.
REQ-006 alu_res_in  in  32  byte address for loads/stores, or ALU result.
REQ-007 val_rm_in  in  32  store data.
REQ-008 dest_in  in  4  destination register index.
REQ-009 wb_enable_out, mem_read_out  out  1 each; alu_res_out  out  32; dest_out  out  4: combinational pass-through of the matching inputs.
REQ-010 mem_data_out  out  32  registered load data.
REQ-011 ready_out  out  1  high when no access is pending or the access completes this cycle.
REQ-012 freeze_out  out  1  equals ~ready_out; holds IF/ID/EXE registers.
REQ-013 sram_addr  out  18  half-word address; sram_we_n  out  1  active-low write strobe.
REQ-014 sram_dq_out  out  16; sram_dq_oe  out  1; sram_dq_in  in  16: split bidirectional data bus.

Function
REQ-015 FSM states: IDLE, LO, HI, DONE.
REQ-016 In IDLE, a request (mem_read_in or mem_write_in) drives ready_out low and moves the FSM to LO; with no request the FSM stays in IDLE and ready_out is high.
REQ-017 If both mem_read_in and mem_write_in are asserted, the access is a write.
REQ-018 Address: word = (alu_res_in - BASE_ADDR) >> 2, computed modulo 2^32, keeping the low 17 bits; LO uses sram_addr = {word,0} and HI uses {word,1}.
REQ-019 Write in LO: sram_dq_out = val_rm_in[15:0]; in HI: sram_dq_out = val_rm_in[31:16]; sram_we_n low and sram_dq_oe high for both phases.
REQ-020 Read: sram_we_n and sram_dq_oe stay high and low respectively; sram_dq_in is sampled on the last cycle of LO into bits [15:0] and of HI into bits [31:16].
REQ-021 mem_data_out is updated only by reads, is valid from DONE onward, and holds until the next read.
REQ-022 LO and HI each last 1 cycle, then the FSM moves to the next state (LO to HI, HI to DONE).
REQ-023 In DONE, ready_out is high and the FSM returns to IDLE on the next edge; the upstream register advances on that same edge, so IDLE sees the next instruction.
REQ-024 Stall length is exactly 3 cycles per access without SRAM_WAIT_EN.
REQ-025 Outside LO and HI: sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0.

Reset
REQ-026 While rst is high at a clock edge:
- FSM goes to IDLE and the wait counter clears;
- mem_data_out is cleared to 0;
- sram_we_n = 1 and sram_dq_oe = 0 from the next cycle.
REQ-027 Reset mid-access (LO or HI) aborts the access; SRAM contents already written stay as written.

Configuration
REQ-028 With macro SRAM_WAIT_EN defined, LO and HI each last WAIT_CYCLES+1 cycles using a down-counter reloaded on every phase entry; the stall is 1 + 2*(WAIT_CYCLES+1) cycles.
REQ-029 Without SRAM_WAIT_EN, the counter logic is absent and REQ-022/REQ-024 timing applies.

Verification
REQ-030 Store 0x12345678 at alu_res_in = 1024 -> SRAM[0] = 0x5678, SRAM[1] = 0x1234; ready_out low exactly 3 cycles.
REQ-031 Load from 1024 after REQ-030 -> mem_data_out = 0x12345678 in DONE; sram_we_n never low during the load.
REQ-032 Non-memory instruction (both mem bits 0), alu_res_in = 0xDEAD -> ready_out stays high, alu_res_out = 0xDEAD, no SRAM strobes.
REQ-033 mem_read_in and mem_write_in both 1, val_rm_in = 0xAAAA5555, address 1028 -> write performed: SRAM[2] = 0x5555, SRAM[3] = 0xAAAA.
REQ-034 rst asserted during HI of a store -> next cycle FSM in IDLE, sram_we_n = 1, mem_data_out = 0, ready_out high.
REQ-035 SRAM_WAIT_EN defined, WAIT_CYCLES = 2, load from 1032 -> ready_out low exactly 7 cycles, sram_addr = 4 for 3 cycles then 5 for 3 cycles.
